// File: rtl/playfield_engine.sv
// playfield_engine: CPU-programmable playfield renderer. Bus writes land in
// staging registers; the active set is refreshed from them at the start of
// every scanline (hpos == 0 strobe) so mid-line writes never tear the image.
// Output is 24-bit RGB expanded from RGB332, plus a scanline-compare IRQ.
//
// Bus semantics: a write is accepted in every cycle write_enable is high,
// independent of enable, with no wait states. A read happens in a cycle with
// enable && !write_enable; data_out carries the value on the following cycle
// and holds it until the next read.
module playfield_engine #(
   parameter int PF_BITS   = 22,
   parameter int PIX_SHIFT = 4,
   parameter int H_START   = 88,
   parameter int BORDER    = 8
) (
   input  logic       raw_clk,
   input  logic       reset,
   input  logic       pixel_enable,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       in_image,
   input  logic       enable,
   input  logic       write_enable,
   input  logic [3:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic       line_irq
);

   // Playfield width in pixels (both halves) and 11-bit geometry constants.
   localparam int          PF_W       = 2 * PF_BITS * (1 << PIX_SHIFT);
   localparam logic [10:0] H_START_11 = 11'(H_START);
   localparam logic [10:0] BORDER_11  = 11'(BORDER);
   localparam logic [10:0] PF_END_11  = 11'(BORDER + PF_W);
   localparam logic [10:0] PF_BITS_11 = 11'(PF_BITS);
   localparam logic [31:0] PF_MASK    = 32'((64'd1 << PF_BITS) - 64'd1);

   // Staged (CPU-visible) registers.
   logic [31:0] pf_stage_q, pf_stage_d;
   logic [7:0]  fg_stage_q, fg_stage_d;
   logic [7:0]  bg_stage_q, bg_stage_d;
   logic [7:0]  border_stage_q, border_stage_d;
   logic [2:0]  ctrl_stage_q, ctrl_stage_d;
   logic [9:0]  cmp_q, cmp_d;

   // Active registers used by the renderer for the current line.
   logic [31:0] pf_act_q, pf_act_d;
   logic [7:0]  fg_act_q, fg_act_d;
   logic [7:0]  bg_act_q, bg_act_d;
   logic [7:0]  border_act_q, border_act_d;
   logic        mirror_act_q, mirror_act_d;
   logic        pfen_act_q, pfen_act_d;

   logic        line_hit_q, line_hit_d;
   logic [7:0]  data_out_q, data_out_d;
   logic [23:0] rgb_q, rgb_d;

   logic        rd_en;
   logic        line_start;
   logic [7:0]  rd_data;

   // Pixel pipeline intermediates.
   logic [10:0] x;
   logic [10:0] rel;
   logic [10:0] idx;
   logic [10:0] j;
   logic [10:0] bit_sel;
   logic        pix_on;
   logic [23:0] rgb_pix;

   assign rd_en      = enable && !write_enable;
   assign line_start = pixel_enable && (hpos == 10'd0);

   function automatic logic [23:0] expand332(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6],
              c[4:2], c[4:2], c[4:3],
              c[1:0], c[1:0], c[1:0], c[1:0]};
   endfunction

   // Staged register writes, line-start latch of the active set, line_hit.
   always_comb begin
      pf_stage_d     = pf_stage_q;
      fg_stage_d     = fg_stage_q;
      bg_stage_d     = bg_stage_q;
      border_stage_d = border_stage_q;
      ctrl_stage_d   = ctrl_stage_q;
      cmp_d          = cmp_q;
      if (write_enable) begin
         case (address)
            4'h0:    pf_stage_d[7:0]   = data_in;
            4'h1:    pf_stage_d[15:8]  = data_in;
            4'h2:    pf_stage_d[23:16] = data_in;
            4'h3:    pf_stage_d[31:24] = data_in;
            4'h4:    fg_stage_d        = data_in;
            4'h5:    bg_stage_d        = data_in;
            4'h6:    border_stage_d    = data_in;
            4'h7:    ctrl_stage_d      = data_in[2:0];
            4'h8:    cmp_d[7:0]        = data_in;
            4'h9:    cmp_d[9:8]        = data_in[1:0];
            default: ;
         endcase
      end
      // Bits beyond the playfield width are never stored.
      pf_stage_d = pf_stage_d & PF_MASK;

      // The latch copies the _q values, so a same-cycle write lands next line.
      pf_act_d     = pf_act_q;
      fg_act_d     = fg_act_q;
      bg_act_d     = bg_act_q;
      border_act_d = border_act_q;
      mirror_act_d = mirror_act_q;
      pfen_act_d   = pfen_act_q;
      if (line_start) begin
         pf_act_d     = pf_stage_q;
         fg_act_d     = fg_stage_q;
         bg_act_d     = bg_stage_q;
         border_act_d = border_stage_q;
         mirror_act_d = ctrl_stage_q[0];
         pfen_act_d   = ctrl_stage_q[1];
      end

      // A set in the same cycle as a status-read clear wins.
      line_hit_d = line_hit_q;
      if (rd_en && (address == 4'hA)) line_hit_d = 1'b0;
      if (line_start && (vpos == cmp_q)) line_hit_d = 1'b1;
   end

   // Read mux; data_out only changes on a read cycle.
   always_comb begin
      rd_data = 8'h00;
      case (address)
         4'h0:    rd_data = pf_stage_q[7:0];
         4'h1:    rd_data = pf_stage_q[15:8];
         4'h2:    rd_data = pf_stage_q[23:16];
         4'h3:    rd_data = pf_stage_q[31:24];
         4'h4:    rd_data = fg_stage_q;
         4'h5:    rd_data = bg_stage_q;
         4'h6:    rd_data = border_stage_q;
         4'h7:    rd_data = {5'b0, ctrl_stage_q};
         4'h8:    rd_data = cmp_q[7:0];
         4'h9:    rd_data = {6'b0, cmp_q[9:8]};
         4'hA:    rd_data = {6'b0, in_image, line_hit_q};
         4'hB:    rd_data = vpos[7:0];
         default: rd_data = 8'h00;
      endcase
      data_out_d = rd_en ? rd_data : data_out_q;
   end

   // Pixel geometry: black outside the image, border, then playfield bits.
   always_comb begin
      x   = {1'b0, hpos} - H_START_11;
      rel = x - BORDER_11;
      idx = rel >> PIX_SHIFT;
      j   = idx - PF_BITS_11;
      if (idx < PF_BITS_11) begin
         bit_sel = PF_BITS_11 - 11'd1 - idx;
      end else if (mirror_act_q) begin
         bit_sel = j;
      end else begin
         bit_sel = PF_BITS_11 - 11'd1 - j;
      end
      pix_on = |(pf_act_q & (32'd1 << bit_sel));

      if (!in_image || ({1'b0, hpos} < H_START_11)) begin
         rgb_pix = 24'h000000;
      end else if ((x < BORDER_11) || (x >= PF_END_11)) begin
         rgb_pix = expand332(border_act_q);
      end else if (pfen_act_q && pix_on) begin
         rgb_pix = expand332(fg_act_q);
      end else begin
         rgb_pix = expand332(bg_act_q);
      end

      rgb_d = pixel_enable ? rgb_pix : rgb_q;
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge raw_clk) begin
      if (reset) begin
         pf_stage_q     <= '0;
         fg_stage_q     <= '0;
         bg_stage_q     <= '0;
         border_stage_q <= '0;
         ctrl_stage_q   <= '0;
         cmp_q          <= '0;
         pf_act_q       <= '0;
         fg_act_q       <= '0;
         bg_act_q       <= '0;
         border_act_q   <= '0;
         mirror_act_q   <= 1'b0;
         pfen_act_q     <= 1'b0;
         line_hit_q     <= 1'b0;
         data_out_q     <= '0;
         rgb_q          <= '0;
      end else begin
         pf_stage_q     <= pf_stage_d;
         fg_stage_q     <= fg_stage_d;
         bg_stage_q     <= bg_stage_d;
         border_stage_q <= border_stage_d;
         ctrl_stage_q   <= ctrl_stage_d;
         cmp_q          <= cmp_d;
         pf_act_q       <= pf_act_d;
         fg_act_q       <= fg_act_d;
         bg_act_q       <= bg_act_d;
         border_act_q   <= border_act_d;
         mirror_act_q   <= mirror_act_d;
         pfen_act_q     <= pfen_act_d;
         line_hit_q     <= line_hit_d;
         data_out_q     <= data_out_d;
         rgb_q          <= rgb_d;
      end
   end

   assign data_out = data_out_q;
   assign red      = rgb_q[23:16];
   assign green    = rgb_q[15:8];
   assign blue     = rgb_q[7:0];
   // irq_enable acts immediately from the staged ctrl register.
   assign line_irq = line_hit_q & ctrl_stage_q[2];

endmodule

// File: doc/playfield_engine.md
# playfield_engine

Parametrised playfield renderer: the next generation of the fixed 22-bit, 16-pixel, red/blue playfield logic in the console peripherals block. It holds CPU-writable playfield bits, three RGB332 colour registers and a mode register. CPU writes land in staging registers, which are copied into the active set once per scanline so that mid-line writes never tear. It produces 24-bit RGB for the HDMI encoder and raises a scanline-compare interrupt for CPU line-timed effects.

## Interface
- PF_BITS, 22: playfield bits per half-screen, 1..32.
- PIX_SHIFT, 4: log2 of pixels per playfield bit.
- H_START, 88: first hpos of the visible image.
- BORDER, 8: border width in pixels on each side of the playfield.
- raw_clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- pixel_enable  input  1  one-cycle strobe per pixel; hpos, vpos and in_image are valid while it is high.
- hpos  input  10  horizontal position from the HDMI timing generator.
- vpos  input  10  vertical position.
- in_image  input  1  high inside the visible area.
- enable  input  1  bus select for reads.
- write_enable  input  1  bus write strobe; writes do not require enable.
- address  input  4  register index.
- data_in  input  8  write data.
- data_out  output  8  registered read data.
- red, green, blue  output  8 each  pixel colour.
- line_irq  output  1  line-compare interrupt, level.

## Operation
- Staged registers, written when write_enable is high:
  - 0x0..0x3: playfield byte n loads pf_stage[8n+7:8n]. Bits at or above PF_BITS are discarded.
  - 0x4: fg colour, RGB332.
  - 0x5: bg colour, RGB332.
  - 0x6: border colour, RGB332.
  - 0x7: ctrl. bit0 = mirror (1) / repeat (0); bit1 = playfield enable; bit2 = irq_enable.
  - 0x8: cmp[7:0].
  - 0x9: cmp[9:8] from data_in[1:0].
- Active latch: on pixel_enable && hpos == 0, the active pf, colours and ctrl take the staged values.
  - If a write occurs in the same cycle, the latch takes the pre-write staged value. The write applies from the next line.
  - cmp and irq_enable take effect immediately and are not latched.
- Reads, when enable && !write_enable:
  - 0x0..0x9: staged value.
  - 0xA: status {6'b0, in_image, line_hit}; this read clears line_hit.
  - 0xB: vpos[7:0] sampled at the read.
  - 0xC..0xF: read as 0.
- Pixel geometry, with x = hpos − H_START and W = 2·PF_BITS·2^PIX_SHIFT:
  - !in_image or hpos < H_START: black (0,0,0).
  - x < BORDER or x ≥ BORDER+W: border colour.
  - Otherwise idx = (x − BORDER) >> PIX_SHIFT.
    - idx < PF_BITS: bit = PF_BITS−1−idx, so the MSB is leftmost.
    - Otherwise j = idx − PF_BITS. Mirror: bit = j. Repeat: bit = PF_BITS−1−j.
  - Colour = pf_active[bit] ? fg : bg. If playfield enable = 0, bg is used everywhere in the playfield region.
- RGB332 expansion: red = {r,r,r[2:1]}, green = {g,g,g[2:1]}, blue = {b,b,b,b}.
- All position arithmetic is done at 11 bits, so there is no underflow on hpos < H_START.
- line_hit:
  - Set on pixel_enable && hpos == 0 && vpos == cmp.
  - Cleared by a status read; if set and clear occur in the same cycle, set wins.
  - line_irq = line_hit & irq_enable.

## Timing
- Reset: all staged and active registers are 0, line_hit = 0, data_out = 0, RGB = 0, line_irq = 0.
- Reset applied mid-line: RGB goes to 0 on the next edge and stays black until pixel_enable occurs after reset deasserts.
- RGB updates on the edge where pixel_enable is high and holds between strobes: one-strobe latency.
- data_out is valid one cycle after the read cycle and holds its value until the next read.
- line_irq asserts one cycle after the hpos == 0 strobe. It deasserts one cycle after the status read.
- Writes are single-cycle; no wait states.

## Test plan
- Defaults. Write pf bytes 0x00, 0x00, 0x20 (pf = 22'h200000), fg = 0xE0, bg = 0x03, border = 0x1C, ctrl = 0x02. Drive a full line.
  - hpos 88..95: RGB = 00FF00.
  - hpos 96..111: FF0000.
  - hpos 112: 0000FF.
  - hpos 448..463: FF0000 (repeat mode).
  - hpos 800..807: 00FF00.
- Set ctrl = 0x03 (mirror). On the next line: hpos 448..463 = 0000FF and hpos 784..799 = FF0000.
- Write pf mid-line at hpos 300. The rest of the line is unchanged; the new pattern appears from the next line. Also write pf in the same cycle as the hpos == 0 strobe: the old value is used for that line.
- Set cmp = 0x105 and ctrl bit2 = 1.
  - At vpos 261, hpos 0: line_irq = 1 one cycle later.
  - Read 0xA: returns 0x01; line_irq = 0 one cycle after the read.
  - Status read coinciding with a new set: line_hit stays 1.
- With hpos < 88 or in_image = 0: RGB = 000000. Assert reset mid-line: all outputs are 0 the next cycle and all registers read 0.
- Instantiate with PF_BITS = 20, PIX_SHIFT = 4, BORDER = 40, pf = 20'h80001, fg = 0xFF, repeat mode.
  - hpos 128..143 and hpos 432..447: FFFFFF.
  - Writes to pf bits 20..31 read back as 0.
